// File: rtl/fdivsqrt_iterctl_if.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iterctl_if
// Handshake bundle between the issue/pipeline logic and the divide/sqrt
// iteration sequencer.
//   master : issue side. Drives StartE, SpecialCaseE, IntDivE, IntCyclesE,
//            FlushE and StallM. Receives IFDivStartE, FDivBusyE, FDivDoneE.
//   slave  : sequencer side. The same signals with directions reversed.
// ---------------------------------------------------------------------------
interface fdivsqrt_iterctl_if #(
  parameter int CNTW = 7
);
  logic            StartE;
  logic            SpecialCaseE;
  logic            IntDivE;
  logic [CNTW-1:0] IntCyclesE;
  logic            FlushE;
  logic            StallM;
  logic            IFDivStartE;
  logic            FDivBusyE;
  logic            FDivDoneE;

  modport master (
    output StartE, SpecialCaseE, IntDivE, IntCyclesE, FlushE, StallM,
    input  IFDivStartE, FDivBusyE, FDivDoneE
  );

  modport slave (
    input  StartE, SpecialCaseE, IntDivE, IntCyclesE, FlushE, StallM,
    output IFDivStartE, FDivBusyE, FDivDoneE
  );
endinterface

// File: rtl/fdivsqrt_iterctl.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iterctl
// Control sequencer for the divide/square-root iteration datapath.
// It accepts an operation in IDLE, then pulses the datapath load strobe and
// holds the register enable for the iteration count. Special-case operands
// skip straight to DONE. DONE is held while Memory stalls.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   ctl    : fdivsqrt_iterctl_if.slave
//            in  StartE, SpecialCaseE, IntDivE, IntCyclesE, FlushE, StallM
//            out IFDivStartE (datapath load), FDivBusyE (register enable /
//                pipeline stall), FDivDoneE (result ready)
// ---------------------------------------------------------------------------
module fdivsqrt_iterctl #(
  parameter int DIVb      = 55,
  parameter int RADIX     = 4,
  parameter int DIVCOPIES = 2,
  parameter int CNTW      = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  fdivsqrt_iterctl_if.slave    ctl
);

  localparam int LOGR     = (RADIX == 4) ? 2 : 1;
  localparam int BITSPC   = LOGR * DIVCOPIES;
  localparam int FPCYCLES = (DIVb + 1 + BITSPC - 1) / BITSPC;
  localparam logic [CNTW-1:0] FPSTEP = CNTW'(FPCYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] step, step_nxt;
  logic [CNTW-1:0] step_init;
  logic            armed;
  logic            accept;

  // armed is cleared by reset and set on the first edge afterwards, which
  // keeps every output low during reset and in the first cycle after it.
  assign accept = ctl.StartE & ~ctl.FlushE & armed & (state == IDLE);

  // Step is loaded with N-1 so BUSY lasts exactly N cycles; an integer count
  // of zero still runs one iteration.
  always_comb begin
    step_init = FPSTEP;
    if (ctl.IntDivE) begin
      if (ctl.IntCyclesE == '0) step_init = '0;
      else                      step_init = ctl.IntCyclesE - CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    if (ctl.FlushE) begin
      // Flush outranks completion and Memory acceptance.
      state_nxt = IDLE;
      step_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ctl.SpecialCaseE) begin
              state_nxt = DONE;
            end else begin
              state_nxt = BUSY;
              step_nxt  = step_init;
            end
          end
        end
        BUSY: begin
          if (step != '0) step_nxt  = step - CNTW'(1);
          else            state_nxt = DONE;
        end
        DONE: begin
          if (!ctl.StallM) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          step_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctl.IFDivStartE = accept & ~ctl.SpecialCaseE;
    ctl.FDivBusyE   = (accept & ~ctl.SpecialCaseE) | (state == BUSY);
    ctl.FDivDoneE   = (state == DONE);
  end

endmodule

// File: tb/tb_fdivsqrt_iterctl.sv
// ---------------------------------------------------------------------------
// tb_fdivsqrt_iterctl
// Two sequencers: dut0 with default parameters (14 FP cycles) and dut1 with
// RADIX=2, DIVCOPIES=1 (56 FP cycles). The stimulus pushes the expected
// completion record of each operation into a per-DUT queue. The monitor
// watches the outputs on the falling edge and pops one record per done pulse.
// ---------------------------------------------------------------------------
module tb_fdivsqrt_iterctl;

  typedef struct {
    int done_cyc;   // cycle where FDivDoneE first rises
    int busy;       // busy cycles counted from the last start strobe
    int strobes;    // start strobes seen since the previous done
    int dlen;       // cycles FDivDoneE stays high
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  fdivsqrt_iterctl_if #(.CNTW(7)) ifc0();
  fdivsqrt_iterctl_if #(.CNTW(7)) ifc1();

  fdivsqrt_iterctl #(.DIVb(55), .RADIX(4), .DIVCOPIES(2), .CNTW(7)) dut0 (
    .clk(clk), .reset(reset), .ctl(ifc0)
  );
  fdivsqrt_iterctl #(.DIVb(55), .RADIX(2), .DIVCOPIES(1), .CNTW(7)) dut1 (
    .clk(clk), .reset(reset), .ctl(ifc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   failures = 0;
  logic final_chk = 1'b0;

  function automatic exp_t mk(input int dc, input int b, input int s, input int l);
    exp_t e;
    e.done_cyc = dc; e.busy = b; e.strobes = s; e.dlen = l;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0d expected=%0d", name, d, cyc, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   busy_cnt[2];
  int   strobe_cnt[2];
  int   dlen[2];
  logic in_done[2];
  exp_t cur[2];
  logic prev_rst;
  logic fin_done;
  logic s_st, s_bz, s_dn;

  initial begin
    prev_rst = 1'b1;
    fin_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; strobe_cnt[d] = 0; dlen[d] = 0; in_done[d] = 1'b0;
      cur[d] = mk(0, 0, 0, 0);
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          s_st = ifc0.IFDivStartE; s_bz = ifc0.FDivBusyE; s_dn = ifc0.FDivDoneE;
        end else begin
          s_st = ifc1.IFDivStartE; s_bz = ifc1.FDivBusyE; s_dn = ifc1.FDivDoneE;
        end
        if (reset) begin
          chk("rst_outputs", d, int'({s_st, s_bz, s_dn}), 0);
          busy_cnt[d] = 0; strobe_cnt[d] = 0; dlen[d] = 0; in_done[d] = 1'b0;
        end else begin
          if (prev_rst) chk("post_rst_outputs", d, int'({s_st, s_bz, s_dn}), 0);
          if (s_st) begin
            chk("strobe_implies_busy", d, int'(s_bz), 1);
            busy_cnt[d] = 1;
            strobe_cnt[d]++;
          end else if (s_bz) begin
            busy_cnt[d]++;
          end
          if (s_dn) begin
            chk("busy_in_done", d, int'(s_bz), 0);
            if (!in_done[d]) begin
              if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                chk("unexpected_done", d, 1, 0);
                cur[d] = mk(cyc, busy_cnt[d], strobe_cnt[d], 1);
              end else begin
                cur[d] = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("done_cycle", d, cyc, cur[d].done_cyc);
                chk("busy_cycles", d, busy_cnt[d], cur[d].busy);
                chk("start_strobes", d, strobe_cnt[d], cur[d].strobes);
              end
              in_done[d] = 1'b1;
              dlen[d] = 1;
            end else begin
              dlen[d]++;
            end
          end else if (in_done[d]) begin
            chk("done_length", d, dlen[d], cur[d].dlen);
            in_done[d] = 1'b0;
            busy_cnt[d] = 0;
            strobe_cnt[d] = 0;
          end
        end
      end
      if (final_chk && !fin_done) begin
        chk("pending_ops", 0, sb0.size(), 0);
        chk("pending_ops", 1, sb1.size(), 0);
        fin_done = 1'b1;
      end
      prev_rst = reset;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    ifc0.StartE = 0; ifc0.SpecialCaseE = 0; ifc0.IntDivE = 0; ifc0.IntCyclesE = '0;
    ifc0.FlushE = 0; ifc0.StallM = 0;
    ifc1.StartE = 0; ifc1.SpecialCaseE = 0; ifc1.IntDivE = 0; ifc1.IntCyclesE = '0;
    ifc1.FlushE = 0; ifc1.StallM = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Presents a one-cycle request; t0 is the cycle the request is visible.
  task automatic issue(input int d, input logic intdiv, input logic [6:0] n,
                       input logic special, output int t0);
    next_cycle();
    if (d == 0) begin
      ifc0.StartE = 1; ifc0.IntDivE = intdiv; ifc0.IntCyclesE = n; ifc0.SpecialCaseE = special;
    end else begin
      ifc1.StartE = 1; ifc1.IntDivE = intdiv; ifc1.IntCyclesE = n; ifc1.SpecialCaseE = special;
    end
    t0 = cyc;
    next_cycle();
    if (d == 0) begin
      ifc0.StartE = 0; ifc0.IntDivE = 0; ifc0.IntCyclesE = '0; ifc0.SpecialCaseE = 0;
    end else begin
      ifc1.StartE = 0; ifc1.IntDivE = 0; ifc1.IntCyclesE = '0; ifc1.SpecialCaseE = 0;
    end
  endtask

  initial begin
    int t0;
    int t1;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) next_cycle();

    // FP divide: busy t0..t0+14, done at t0+15
    issue(0, 1'b0, 7'd0, 1'b0, t0);
    sb0.push_back(mk(t0 + 15, 15, 1, 1));
    repeat (20) next_cycle();

    // Integer divide, 5 cycles
    issue(0, 1'b1, 7'd5, 1'b0, t0);
    sb0.push_back(mk(t0 + 6, 6, 1, 1));
    repeat (10) next_cycle();

    // Integer divide, count 0 runs as 1
    issue(0, 1'b1, 7'd0, 1'b0, t0);
    sb0.push_back(mk(t0 + 2, 2, 1, 1));
    repeat (6) next_cycle();

    // Special case: no strobe, no busy, done next cycle
    issue(0, 1'b0, 7'd0, 1'b1, t0);
    sb0.push_back(mk(t0 + 1, 0, 0, 1));
    repeat (5) next_cycle();

    // Memory stalled for 3 cycles of DONE: done held 4 cycles
    ifc0.StallM = 1;
    issue(0, 1'b0, 7'd0, 1'b0, t0);
    sb0.push_back(mk(t0 + 15, 15, 1, 4));
    while (cyc != t0 + 18) next_cycle();
    ifc0.StallM = 0;
    repeat (5) next_cycle();

    // Flush at cycle 7 of an FP op, new start at cycle 8 with full count
    issue(0, 1'b0, 7'd0, 1'b0, t0);
    while (cyc != t0 + 7) next_cycle();
    ifc0.FlushE = 1;
    next_cycle();
    ifc0.FlushE = 0;
    ifc0.StartE = 1;
    t1 = cyc;
    sb0.push_back(mk(t1 + 15, 15, 2, 1));
    next_cycle();
    ifc0.StartE = 0;
    repeat (20) next_cycle();

    // Asynchronous reset mid-BUSY: no done pulse afterwards
    issue(0, 1'b0, 7'd0, 1'b0, t0);
    while (cyc != t0 + 5) next_cycle();
    @(posedge clk);
    #2 reset = 1'b1;
    #20;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (20) next_cycle();

    // Radix-2, one copy: 56 FP cycles
    issue(1, 1'b0, 7'd0, 1'b0, t0);
    sb1.push_back(mk(t0 + 57, 57, 1, 1));
    repeat (65) next_cycle();

    final_chk = 1'b1;
    repeat (3) next_cycle();
    if (!fin_done) begin
      failures++;
      $display("FAIL monitor_final actual=0 expected=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
